regfile_write_arb: RTL and testbench

REGFILE_WRITE_ARB -- requirements
Module: regfile_write_arb

---
 rtl/regfile_write_arb.sv | 105 ++++++++++
 tb/tb_regfile_write_arb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arb.sv
// Write-port arbiter for a register file: round-robin between two requesters,
// with a bulk-clear mode that zeroes every register, one index per cycle.
module regfile_write_arb #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit PROTECT_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0Valid,
  input  logic [ADDR_W-1:0] req0Reg,
  input  logic [DATA_W-1:0] req0Data,
  output logic              req0Ready,
  input  logic              req1Valid,
  input  logic [ADDR_W-1:0] req1Reg,
  input  logic [DATA_W-1:0] req1Data,
  output logic              req1Ready,
  input  logic              clearStart,
  output logic              clearBusy,
  output logic              clearDone,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_next;
  logic              last_grant;  // 1: requester 1 was granted most recently

  assign count_next = count + ONE;

  always_comb begin
    req0Ready = 1'b0;
    req1Ready = 1'b0;
    if (reset && state == IDLE && !clearStart) begin
      if (req0Valid && (!req1Valid || last_grant))
        req0Ready = 1'b1;
      else if (req1Valid)
        req1Ready = 1'b1;
    end
  end

  // Write-port outputs are registered: the CLEAR cycle for index k is set up
  // on the edge that enters that cycle, so writeReg tracks count in CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
      regWrite   <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
      clearBusy  <= 1'b0;
      clearDone  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          regWrite  <= 1'b0;
          clearDone <= 1'b0;
          if (clearStart) begin
            state     <= CLEAR;
            count     <= '0;
            regWrite  <= 1'b1;
            writeReg  <= '0;
            writeData <= '0;
            clearBusy <= 1'b1;
            clearDone <= (LAST_IDX == '0);
          end else if (req0Ready) begin
            regWrite   <= !(PROTECT_ZERO && req0Reg == '0);
            writeReg   <= req0Reg;
            writeData  <= req0Data;
            last_grant <= 1'b0;
          end else if (req1Ready) begin
            regWrite   <= !(PROTECT_ZERO && req1Reg == '0);
            writeReg   <= req1Reg;
            writeData  <= req1Data;
            last_grant <= 1'b1;
          end
        end
        CLEAR: begin
          count <= count_next;
          if (count == LAST_IDX) begin
            state     <= IDLE;
            regWrite  <= 1'b0;
            clearBusy <= 1'b0;
            clearDone <= 1'b0;
          end else begin
            regWrite  <= 1'b1;
            writeReg  <= count_next;
            writeData <= '0;
            clearDone <= (count_next == LAST_IDX);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arb.sv
// Directed bench for regfile_write_arb: vector table for arbitration and
// protection, hand sequences for bulk clear and reset abort.
module tb_regfile_write_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0Valid, req1Valid, clearStart;
  logic [4:0]  req0Reg, req1Reg;
  logic [31:0] req0Data, req1Data;
  logic        req0Ready, req1Ready, clearBusy, clearDone, regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;
  logic saw_done = 1'b0;

  regfile_write_arb #(.DATA_W(32), .ADDR_W(5), .PROTECT_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .req0Valid(req0Valid), .req0Reg(req0Reg), .req0Data(req0Data), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Reg(req1Reg), .req1Data(req1Data), .req1Ready(req1Ready),
    .clearStart(clearStart), .clearBusy(clearBusy), .clearDone(clearDone),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && clearDone) saw_done <= 1'b1;

  typedef struct {
    logic v0; logic [4:0] a0; logic [31:0] d0;
    logic v1; logic [4:0] a1; logic [31:0] d1;
    logic er0; logic er1; logic ewe;
    logic chk; logic [4:0] ewr; logic [31:0] ewd;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Pointer starts at requester 1, so requester 0 wins the first conflict.
    vecs[0]  = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 1, 1, 5'd1, 32'h11};
    vecs[1]  = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 1, 1, 5'd2, 32'h22};
    vecs[2]  = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, 1, 1, 5'd1, 32'h11};
    vecs[3]  = '{1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, 1, 1, 5'd2, 32'h22};
    vecs[4]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, 1, 5'd5, 32'hDEADBEEF};
    vecs[5]  = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF};
    vecs[6]  = '{0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1, 0, 0, 5'd0, 32'h0};
    vecs[7]  = '{1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 0, 1, 1, 5'd3, 32'h33};
    vecs[8]  = '{0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 0, 1, 1, 1, 5'd7, 32'h77};
    vecs[9]  = '{1, 5'd0, 32'hAAAA, 0, 5'd0, 32'h0, 1, 0, 0, 0, 5'd0, 32'h0};
    vecs[10] = '{0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 1, 1, 1, 5'd9, 32'h99};
    vecs[11] = '{0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 1, 5'd9, 32'h99};

    reset = 1'b0; clearStart = 1'b0;
    req0Valid = 1'b1; req0Reg = 5'd3; req0Data = 32'h5;
    req1Valid = 1'b1; req1Reg = 5'd4; req1Data = 32'h6;
    #12;
    chk("rst_rdy0", req0Ready, 0);
    chk("rst_rdy1", req1Ready, 0);
    chk("rst_we", regWrite, 0);
    chk("rst_wreg", writeReg, 0);
    chk("rst_wdata", writeData, 0);
    chk("rst_busy", clearBusy, 0);
    chk("rst_done", clearDone, 0);
    next_cycle();
    reset = 1'b1;

    foreach (vecs[i]) begin
      req0Valid = vecs[i].v0; req0Reg = vecs[i].a0; req0Data = vecs[i].d0;
      req1Valid = vecs[i].v1; req1Reg = vecs[i].a1; req1Data = vecs[i].d1;
      #1;
      chk($sformatf("v%0d_rdy0", i), req0Ready, vecs[i].er0);
      chk($sformatf("v%0d_rdy1", i), req1Ready, vecs[i].er1);
      next_cycle();
      chk($sformatf("v%0d_we", i), regWrite, vecs[i].ewe);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_wreg", i), writeReg, vecs[i].ewr);
        chk($sformatf("v%0d_wdata", i), writeData, vecs[i].ewd);
      end
    end

    // Bulk clear with both requesters waiting; pointer says requester 0 is next.
    req0Valid = 1'b1; req0Reg = 5'd6; req0Data = 32'h66;
    req1Valid = 1'b1; req1Reg = 5'd8; req1Data = 32'h88;
    clearStart = 1'b1;
    #1;
    chk("clr_start_rdy0", req0Ready, 0);
    chk("clr_start_rdy1", req1Ready, 0);
    next_cycle();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("clr%0d_we", i), regWrite, 1);
      chk($sformatf("clr%0d_wreg", i), writeReg, i);
      chk($sformatf("clr%0d_wdata", i), writeData, 0);
      chk($sformatf("clr%0d_busy", i), clearBusy, 1);
      chk($sformatf("clr%0d_done", i), clearDone, (i == 31) ? 1 : 0);
      chk($sformatf("clr%0d_rdy", i), {req0Ready, req1Ready}, 0);
      if (i == 3) clearStart = 1'b0;
      next_cycle();
    end
    chk("clr_exit_busy", clearBusy, 0);
    chk("clr_exit_done", clearDone, 0);
    chk("clr_exit_we", regWrite, 0);
    chk("clr_exit_rdy0", req0Ready, 1);
    chk("clr_exit_rdy1", req1Ready, 0);
    next_cycle();
    chk("post_clr_we", regWrite, 1);
    chk("post_clr_wreg", writeReg, 6);
    chk("post_clr_wdata", writeData, 32'h66);

    // Reset in the middle of a clear aborts it without a done pulse.
    req1Valid = 1'b0;
    req0Reg = 5'd12; req0Data = 32'hC0FFEE;
    clearStart = 1'b1;
    next_cycle();
    clearStart = 1'b0;
    saw_done = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 64 && writeReg != 5'd10; k++) next_cycle();
    chk("abort_reach_10", writeReg, 10);
    reset = 1'b0;
    #1;
    chk("abort_we", regWrite, 0);
    chk("abort_wreg", writeReg, 0);
    chk("abort_wdata", writeData, 0);
    chk("abort_busy", clearBusy, 0);
    chk("abort_done", clearDone, 0);
    chk("abort_rdy0", req0Ready, 0);
    next_cycle();
    reset = 1'b1;
    #1;
    chk("release_busy", clearBusy, 0);
    chk("release_rdy0", req0Ready, 1);
    next_cycle();
    chk("release_we", regWrite, 1);
    chk("release_wreg", writeReg, 12);
    chk("release_busy2", clearBusy, 0);
    req0Valid = 1'b0;
    repeat (4) next_cycle();
    chk("abort_no_done", saw_done, 0);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
